dec_counter: RTL and testbench

Down-counting implementation block for the counter refinement-check flow, the decrement-side counterpart of the incrementing counter. It holds an explicit count `v` (the architectural state mapped to the spec model) and an implicit micro-architectural shadow `imp`. The invariant `v == MAX - imp` must hold in every reachable state. Commands arrive over a valid/ready handshake and commit after a fixed latency. A one-cycle `done` marks each commit, which is where the verification wrapper samples the refinement map.

---
 rtl/dec_counter_pkg.sv | 9 +
 rtl/dec_counter_ctrl.sv | 49 ++++
 rtl/dec_counter.sv | 71 +++++++
 tb/tb_dec_counter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/dec_counter_pkg.sv
// dec_counter_pkg: shared op encoding, FSM states and MAX helper for dec_counter
package dec_counter_pkg;
  localparam int OP_W = 2;
  typedef enum logic [OP_W-1:0] {OP_NOP, OP_DEC, OP_LOAD, OP_SUB} op_e;
  typedef enum logic {S_IDLE, S_EXEC} st_e;
  function automatic logic [31:0] max_of(input int w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/dec_counter_ctrl.sv
// dec_counter_ctrl: IDLE/EXEC sequencer producing cmd_ready, accept and the commit strobe
module dec_counter_ctrl
  import dec_counter_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  output logic accept,
  output logic commit
);
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  st_e st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic last;
  assign last = cnt == CW'(LAT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= S_IDLE;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    if (st == S_IDLE) begin
      if (accept && LAT > 1) begin
        st_n  = S_EXEC;
        cnt_n = CW'(1);
      end
    end else if (last) begin
      st_n  = S_IDLE;
      cnt_n = '0;
    end else begin
      cnt_n = cnt + CW'(1);
    end
  end
  // With LAT == 1 the command commits on its own acceptance edge
  always_comb begin
    cmd_ready = st == S_IDLE;
    accept    = cmd_valid && cmd_ready;
    commit    = (LAT == 1) ? accept : (st == S_EXEC && last);
  end
endmodule

// File: rtl/dec_counter.sv
// dec_counter: down counter with explicit v and shadow imp (v == MAX - imp), fixed-latency commit
// Build option: DEC_COUNTER_SAT_EN clamps DEC/SUB at 0 instead of wrapping.
module dec_counter
  import dec_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ui,
  input  logic             cmd_valid,
  input  logic [OP_W-1:0]  cmd_op,
  output logic             cmd_ready,
  output logic             done,
  output logic             uflow,
  output logic [WIDTH-1:0] v_o,
  output logic [WIDTH-1:0] out,
  output logic             inv_ok
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_of(WIDTH));
`ifdef DEC_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic [WIDTH-1:0] v, imp, opnd_q, opnd, dv, di;
  op_e op_q, op;
  logic accept, commit, borrow, sat;
  dec_counter_ctrl #(.LAT(LAT)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .accept    (accept),
    .commit    (commit)
  );
  // LAT == 1 commits on the acceptance edge, before the latches hold the command
  always_comb begin
    op     = (LAT == 1) ? op_e'(cmd_op) : op_q;
    opnd   = (LAT == 1) ? ui : opnd_q;
    borrow = (op == OP_DEC && v == '0) || (op == OP_SUB && opnd > v);
    sat    = SAT && borrow;
    dv     = op == OP_DEC ? v - WIDTH'(1) : op == OP_LOAD ? opnd : op == OP_SUB ? v - opnd : v;
    di     = op == OP_DEC ? imp + WIDTH'(1) : op == OP_LOAD ? ~opnd : op == OP_SUB ? imp + opnd : imp;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v      <= ui;
      imp    <= ~ui;
      done   <= 1'b0;
      uflow  <= 1'b0;
      op_q   <= OP_NOP;
      opnd_q <= '0;
    end else begin
      done  <= commit;
      uflow <= commit && borrow;
      if (accept) begin
        op_q   <= op_e'(cmd_op);
        opnd_q <= ui;
      end
      if (commit) begin
        v   <= sat ? '0 : dv;
        imp <= sat ? MAX : di;
      end
    end
  end
  assign v_o    = v;
  assign out    = v & (MAX - imp);
  assign inv_ok = v == MAX - imp;
endmodule

// File: tb/tb_dec_counter.sv
// tb_dec_counter: LAT=2 and LAT=1 instances driven together and checked against a transaction-level model
module tb_dec_counter;
  localparam int M = 16;
  localparam int LATS[2] = '{2, 1};
`ifdef DEC_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst, cmd_valid;
  logic [1:0] cmd_op;
  logic [3:0] ui;
  logic [1:0] rdy, dn, uf, ok;
  logic [3:0] vo[2], ot[2];
  int n_err = 0, n_chk = 0;
  int mv[2], rem[2], pop[2], pod[2];
  bit ed[2], eu[2];
  always #5 clk = ~clk;

  dec_counter #(.WIDTH(4), .LAT(2)) u_d2 (
    .clk(clk), .rst(rst), .ui(ui), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(rdy[0]), .done(dn[0]), .uflow(uf[0]), .v_o(vo[0]), .out(ot[0]), .inv_ok(ok[0]));
  dec_counter #(.WIDTH(4), .LAT(1)) u_d1 (
    .clk(clk), .rst(rst), .ui(ui), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(rdy[1]), .done(dn[1]), .uflow(uf[1]), .v_o(vo[1]), .out(ot[1]), .inv_ok(ok[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_commit(input int k);
    int t;
    t = pop[k] == 1 ? mv[k] - 1 : pop[k] == 2 ? pod[k] : pop[k] == 3 ? mv[k] - pod[k] : mv[k];
    ed[k] = 1'b1;
    if (t < 0) begin
      eu[k] = 1'b1;
      t = SAT ? 0 : t + M;
    end
    mv[k] = t;
  endtask

  task automatic model(input int k, input bit r, input bit vld, input int op, input int u);
    ed[k] = 1'b0;
    eu[k] = 1'b0;
    if (r) begin
      mv[k] = u;
      rem[k] = 0;
    end else if (rem[k] > 0) begin
      rem[k]--;
      if (rem[k] == 0) do_commit(k);
    end else if (vld) begin
      pop[k] = op;
      pod[k] = u;
      rem[k] = LATS[k] - 1;
      if (rem[k] == 0) do_commit(k);
    end
  endtask

  task automatic step(input bit r, input bit vld, input logic [1:0] op, input logic [3:0] u);
    logic [3:0] imp;
    rst = r; cmd_valid = vld; cmd_op = op; ui = u;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model(k, r, vld, int'(op), int'(u));
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      imp = k == 0 ? u_d2.imp : u_d1.imp;
      chk($sformatf("v%0d", k), 32'(vo[k]), 32'(mv[k]));
      chk($sformatf("imp%0d", k), 32'(imp), 32'(M - 1 - mv[k]));
      chk($sformatf("out%0d", k), 32'(ot[k]), 32'(mv[k]));
      chk($sformatf("inv%0d", k), 32'(ok[k]), 32'd1);
      chk($sformatf("rdy%0d", k), 32'(rdy[k]), 32'(rem[k] == 0));
      chk($sformatf("done%0d", k), 32'(dn[k]), 32'(ed[k]));
      chk($sformatf("uflow%0d", k), 32'(uf[k]), 32'(eu[k]));
    end
  endtask

  initial begin
    step(1, 0, 0, 4'h5);
    chk("rst_v", 32'(vo[0]), 32'h5);
    chk("rst_imp", 32'(u_d2.imp), 32'hA);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    step(0, 1, 1, 4'h0);
    chk("dec_busy", 32'(rdy[0]), 32'd0);
    step(0, 0, 0, 4'h0);
    chk("dec_v", 32'(vo[0]), 32'h4);
    chk("dec_done", 32'(dn[0]), 32'd1);
    step(0, 1, 2, 4'h0);
    step(0, 0, 0, 4'h0);
    step(0, 1, 1, 4'h3);
    step(0, 0, 0, 4'h3);
    chk("dec0_v", 32'(vo[0]), SAT ? 32'h0 : 32'hF);
    chk("dec0_uflow", 32'(uf[0]), 32'd1);
    step(0, 1, 2, 4'h3);
    step(0, 0, 0, 4'h3);
    step(0, 1, 3, 4'h7);
    step(0, 0, 0, 4'h7);
    chk("sub_v", 32'(vo[0]), SAT ? 32'h0 : 32'hC);
    chk("sub_uflow", 32'(uf[0]), 32'd1);
    step(0, 1, 2, 4'h9);
    step(1, 0, 0, 4'h2);
    chk("abort_done", 32'(dn[0]), 32'd0);
    chk("abort_v", 32'(vo[0]), 32'h2);
    chk("abort_imp", 32'(u_d2.imp), 32'hD);
    step(0, 1, 2, 4'h8);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 4'h0);
      chk("lat1_v", 32'(vo[1]), 32'(7 - i));
      chk("lat1_done", 32'(dn[1]), 32'd1);
    end
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
